base_sram_rdq: RTL

Read-request stage for a synchronous single-port SRAM with one-cycle read latency. It accepts a valid/ready stream of address-plus-tag requests and drives the SRAM read enable and address. It captures the read data in a small credit-protected return FIFO and presents data-plus-tag as a valid/ready output stream. It sits where a latch-with-enable stage would otherwise gate the SRAM read enable, and adds the return buffering so read data is never dropped under output backpressure.

---
 rtl/base_sram_pkg.sv | 15 +
 rtl/base_sram_rdq_fifo.sv | 55 +++++
 rtl/base_sram_rdq.sv | 98 +++++++++
 3 files changed

// File: rtl/base_sram_pkg.sv
// Shared helpers for the SRAM read-request stage: pointer sizing and read-data parity check.
package base_sram_pkg;

    localparam int unsigned PARITY_MAX_W = 1025;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Odd parity over data+parity bit: an even XOR flags an error.
    function automatic logic parity_err(input logic [PARITY_MAX_W-1:0] word);
        return ~(^word);
    endfunction

endpackage

// File: rtl/base_sram_rdq_fifo.sv
// Register FIFO holding returned read data plus tag; storage is not reset.
module base_sram_rdq_fifo
    import base_sram_pkg::*;
#(
    parameter int unsigned width = 36,
    parameter int unsigned depth = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [width-1:0]             wdata,
    input  logic                         pop,
    output logic [width-1:0]             rdata,
    output logic                         empty,
    output logic [$clog2(depth+1)-1:0]   count
);

    localparam int unsigned PW = ptr_width(depth);
    localparam int unsigned CW = $clog2(depth + 1);

    logic [width-1:0] store [depth];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            store[wr_ptr] <= wdata;
        end
    end

    // Pointers move independently; occupancy tracks push minus pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = store[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/base_sram_rdq.sv
// SRAM read-request stage with credit-protected return FIFO.
// Define BASE_SRAM_RDQ_PARITY_EN to add a parity bit on sram_rd and the o_perr output.
module base_sram_rdq
    import base_sram_pkg::*;
#(
    parameter int unsigned addr_width = 8,
    parameter int unsigned data_width = 32,
    parameter int unsigned tag_width  = 4,
    parameter int unsigned depth      = 2
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        i_v,
    input  logic [addr_width-1:0]                       i_a,
    input  logic [((tag_width > 0) ? tag_width : 1)-1:0] i_t,
    output logic                                        i_r,
    output logic                                        sram_re,
    output logic [addr_width-1:0]                       sram_ra,
`ifdef BASE_SRAM_RDQ_PARITY_EN
    input  logic [data_width:0]                         sram_rd,
    output logic                                        o_perr,
`else
    input  logic [data_width-1:0]                       sram_rd,
`endif
    output logic                                        o_v,
    output logic [data_width-1:0]                       o_d,
    output logic [((tag_width > 0) ? tag_width : 1)-1:0] o_t,
    input  logic                                        o_r
);

    localparam int unsigned TW = (tag_width > 0) ? tag_width : 1;
    localparam int unsigned CW = $clog2(depth + 1);
`ifdef BASE_SRAM_RDQ_PARITY_EN
    localparam int unsigned EW = data_width + TW + 1;
`else
    localparam int unsigned EW = data_width + TW;
`endif

    logic          inflight;
    logic [TW-1:0] inflight_tag;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] cnt;
    logic          fifo_empty;
    logic          accept;
    logic          pop;
    logic [EW-1:0] wdata;
    logic [EW-1:0] rdata;

    // Credits cover both the read in flight and the buffered responses.
    assign cnt     = CW'(inflight) + fifo_count;
    assign pop     = o_v & o_r;
    assign i_r     = ~reset & ((cnt - CW'(pop)) < CW'(depth));
    assign accept  = i_v & i_r;
    assign sram_re = accept;
    assign sram_ra = i_a;

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= 1'b0;
        end else begin
            inflight <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            inflight_tag <= i_t;
        end
    end

`ifdef BASE_SRAM_RDQ_PARITY_EN
    assign wdata = {parity_err(PARITY_MAX_W'(sram_rd)), sram_rd[data_width-1:0], inflight_tag};
`else
    assign wdata = {sram_rd, inflight_tag};
`endif

    base_sram_rdq_fifo #(
        .width (EW),
        .depth (depth)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign o_v = ~fifo_empty;
    assign o_t = rdata[TW-1:0];
    assign o_d = rdata[TW +: data_width];
`ifdef BASE_SRAM_RDQ_PARITY_EN
    assign o_perr = o_v & rdata[EW-1];
`endif

endmodule
